// File: rtl/des_link_train_ctrl.sv
// Link-training controller: bit-slips the deserializer until the training byte appears,
// then finds the word marker, verifies LOCK_CNT clean words and reports lock/word phase.
module des_link_train_ctrl #(
  parameter logic [7:0] BYTE_PAT    = 8'hBC,
  parameter logic [7:0] WORD_PAT    = 8'h3C,
  parameter int         LOCK_CNT    = 8,
  parameter int         SLIP_WAIT   = 16,
  parameter int         MAX_SLIPS   = 8,
  parameter int         VLD_TIMEOUT = 64
) (
  input  logic       t_clk,
  input  logic       rst_n,
  input  logic       train_en,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic       bitslip,
  output logic [1:0] word_phase,
  output logic       lock,
  output logic       fail,
  output logic [2:0] state_o,
  output logic [2:0] slip_cnt,
  output logic [7:0] los_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(SLIP_WAIT);
  localparam int TW = $clog2(VLD_TIMEOUT);

  localparam logic [2:0]    SLIP_LAST = 3'(MAX_SLIPS - 1);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(VLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_SLIP   = 3'd2,
    S_ALIGN  = 3'd3,
    S_VERIFY = 3'd4,
    S_LOCKED = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    slip_q, slip_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [1:0]    lane_q, lane_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    los_q, los_d;
  logic [1:0]    phase_q, phase_d;
  logic          bitslip_q, bitslip_d;
  logic          lock_q, lock_d;
  logic          fail_q, fail_d;
  logic          is_byte_pat, is_word_pat;

  always_comb begin
    state_d     = state_q;
    slip_d      = slip_q;
    good_d      = good_q;
    lane_d      = lane_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    los_d       = los_q;
    phase_d     = phase_q;
    bitslip_d   = 1'b0;
    good_inc    = good_q + 1'b1;
    is_byte_pat = (byte_in == BYTE_PAT);
    is_word_pat = (byte_in == WORD_PAT);

    // IDLE holds every per-hunt counter at zero so a retry starts clean
    if (state_q == S_IDLE) begin
      slip_d = '0;
      good_d = '0;
      lane_d = '0;
      wait_d = '0;
      tmo_d  = '0;
    end

    if (!train_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HUNT;

        S_HUNT: begin
          if (byte_vld) begin
            if (is_byte_pat || is_word_pat) begin
              state_d = S_ALIGN;
            end else if (slip_q == SLIP_LAST) begin
              state_d = S_FAIL;
            end else begin
              bitslip_d = 1'b1;
              slip_d    = slip_q + 3'd1;
              wait_d    = '0;
              state_d   = S_SLIP;
            end
          end
        end

        S_SLIP: begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = S_HUNT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end

        S_ALIGN: begin
          if (byte_vld) begin
            if (is_word_pat) begin
              lane_d  = '0;
              good_d  = '0;
              state_d = S_VERIFY;
            end else if (!is_byte_pat) begin
              state_d = S_HUNT;
            end
          end
        end

        S_VERIFY: begin
          if (byte_vld) begin
            lane_d = lane_q + 2'd1;
            if ((lane_q == 2'd3) ? !is_word_pat : !is_byte_pat) begin
              good_d  = '0;
              state_d = S_HUNT;
            end else if (lane_q == 2'd3) begin
              good_d = good_inc;
              if (good_inc == GOOD_MAX) begin
                phase_d = lane_q;
                tmo_d   = '0;
                state_d = S_LOCKED;
              end
            end
          end
        end

        S_LOCKED: begin
          // A strobe in the same cycle as an expiring timer wins over the timeout
          if (byte_vld) begin
            tmo_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            slip_d  = '0;
            los_d   = (los_q == 8'hFF) ? los_q : los_q + 8'd1;
            state_d = S_HUNT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end

        S_FAIL: state_d = S_FAIL;

        default: state_d = S_IDLE;
      endcase
    end

    lock_d = (state_d == S_LOCKED);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      slip_q    <= '0;
      good_q    <= '0;
      lane_q    <= '0;
      wait_q    <= '0;
      tmo_q     <= '0;
      los_q     <= '0;
      phase_q   <= '0;
      bitslip_q <= 1'b0;
      lock_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slip_q    <= slip_d;
      good_q    <= good_d;
      lane_q    <= lane_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      los_q     <= los_d;
      phase_q   <= phase_d;
      bitslip_q <= bitslip_d;
      lock_q    <= lock_d;
      fail_q    <= fail_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign word_phase = phase_q;
  assign lock       = lock_q;
  assign fail       = fail_q;
  assign state_o    = state_q;
  assign slip_cnt   = slip_q;
  assign los_cnt    = los_q;

endmodule

// File: tb/tb_des_link_train_ctrl.sv
// Bench for des_link_train_ctrl: table-driven byte stream with an expected-state queue,
// plus hand-written sequences for slip hunting, fail, timeout and async reset.
module tb_des_link_train_ctrl;

  logic       t_clk = 1'b0;
  logic       rst_n;
  logic       train_en;
  logic [7:0] byte_in;
  logic       byte_vld;
  logic       bitslip;
  logic [1:0] word_phase;
  logic       lock;
  logic       fail;
  logic [2:0] state_o;
  logic [2:0] slip_cnt;
  logic [7:0] los_cnt;

  always #5 t_clk = ~t_clk;

  des_link_train_ctrl dut (
    .t_clk      (t_clk),
    .rst_n      (rst_n),
    .train_en   (train_en),
    .byte_in    (byte_in),
    .byte_vld   (byte_vld),
    .bitslip    (bitslip),
    .word_phase (word_phase),
    .lock       (lock),
    .fail       (fail),
    .state_o    (state_o),
    .slip_cnt   (slip_cnt),
    .los_cnt    (los_cnt)
  );

  typedef struct {
    logic [2:0] st;
    logic       lk;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  vec_t vec[40];
  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Bitslip monitor: counts pulses and tracks the tightest spacing seen
  int cyc        = 0;
  int slip_total = 0;
  int last_slip  = -1000;
  int min_gap    = 1000;

  always @(negedge t_clk) begin
    cyc <= cyc + 1;
    if (bitslip === 1'b1) begin
      slip_total <= slip_total + 1;
      if (cyc - last_slip < min_gap) min_gap <= cyc - last_slip;
      last_slip <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int r);
    logic [15:0] t;
    t = {b, b} << (r % 8);
    return t[15:8];
  endfunction

  function automatic logic [7:0] train_byte(input int p);
    return (p % 4 == 3) ? 8'h3C : 8'hBC;
  endfunction

  // One byte every 4 cycles; the state after the strobe is compared against the queue head
  task automatic send_byte(input logic [7:0] b, input bit chk, input string name);
    exp_t e;
    byte_vld = 1'b1;
    byte_in  = b;
    @(negedge t_clk);
    byte_vld = 1'b0;
    if (chk) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s_queue: got empty scoreboard, expected an entry", name);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] %s byte=%02h state=%0d lock=%0d (exp %0d/%0d)", name, b, state_o, lock, e.st, e.lk);
        check({name, "_state"}, int'(state_o), int'(e.st));
        check({name, "_lock"}, int'(lock), int'(e.lk));
      end
    end
    repeat (3) @(negedge t_clk);
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [2:0] st, input logic lk, input string name);
    exp_t e;
    e.st = st;
    e.lk = lk;
    exp_q.push_back(e);
    send_byte(b, 1'b1, name);
  endtask

  task automatic apply_table(input string name);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(vec[i].e);
      send_byte(vec[i].b, 1'b1, name);
    end
  endtask

  initial begin
    int s0;
    int rot_init;
    int pos;
    int r;

    // Aligned stream: 3 bytes in ALIGN, VERIFY until the 8th verified marker, then LOCKED
    for (int i = 0; i < 40; i++) begin
      vec[i].b    = train_byte(i);
      vec[i].e.st = (i < 3) ? 3'd3 : (i < 35) ? 3'd4 : 3'd5;
      vec[i].e.lk = (i >= 35);
    end

    rst_n    = 1'b0;
    train_en = 1'b0;
    byte_vld = 1'b0;
    byte_in  = 8'h00;
    repeat (3) @(negedge t_clk);
    rst_n = 1'b1;
    @(negedge t_clk);
    check("rst_state", int'(state_o), 0);
    check("rst_lock", int'(lock), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_bitslip", int'(bitslip), 0);
    check("rst_slip_cnt", int'(slip_cnt), 0);
    check("rst_los", int'(los_cnt), 0);
    check("rst_phase", int'(word_phase), 0);

    // 1: aligned stream
    train_en = 1'b1;
    @(negedge t_clk);
    check("t1_hunt", int'(state_o), 1);
    s0 = slip_total;
    apply_table("t1");
    check("t1_no_slip", slip_total - s0, 0);
    check("t1_phase", int'(word_phase), 3);
    check("t1_state", int'(state_o), 5);

    // 4: strobe loss while LOCKED, exact 64-cycle timeout
    repeat (60) @(negedge t_clk);
    check("t4_still_locked", int'(lock), 1);
    @(negedge t_clk);
    check("t4_lock_drop", int'(lock), 0);
    check("t4_state_hunt", int'(state_o), 1);
    check("t4_los", int'(los_cnt), 1);
    check("t4_phase_held", int'(word_phase), 3);
    apply_table("t4");
    check("t4_relock", int'(lock), 1);
    check("t4_los_after", int'(los_cnt), 1);

    // train_en low while LOCKED drops lock next cycle
    train_en = 1'b0;
    @(negedge t_clk);
    check("t6_lock_drop", int'(lock), 0);
    check("t6_idle", int'(state_o), 0);

    // 5: corrupt lane 1 of the 5th VERIFY word
    train_en = 1'b1;
    @(negedge t_clk);
    check("t5_hunt", int'(state_o), 1);
    s0 = slip_total;
    send_exp(8'hBC, 3'd3, 1'b0, "t5");
    send_exp(8'hBC, 3'd3, 1'b0, "t5");
    send_exp(8'hBC, 3'd3, 1'b0, "t5");
    send_exp(8'h3C, 3'd4, 1'b0, "t5");
    for (int i = 0; i < 16; i++) send_exp(train_byte(i), 3'd4, 1'b0, "t5");
    send_exp(8'hBC, 3'd4, 1'b0, "t5");
    send_exp(8'hBD, 3'd1, 1'b0, "t5_bad");
    send_exp(8'hBC, 3'd3, 1'b0, "t5");
    send_exp(8'h3C, 3'd4, 1'b0, "t5");
    for (int i = 0; i < 32; i++)
      send_exp(train_byte(i), (i == 31) ? 3'd5 : 3'd4, (i == 31), "t5");
    check("t5_no_slip", slip_total - s0, 0);

    // 2: stream rotated by 3 bits; each bitslip undoes one bit of rotation
    train_en = 1'b0;
    @(negedge t_clk);
    rot_init = 3 + slip_total;
    s0 = slip_total;
    train_en = 1'b1;
    @(negedge t_clk);
    pos = 0;
    for (int k = 0; k < 200 && lock !== 1'b1; k++) begin
      r = (((rot_init - slip_total) % 8) + 8) % 8;
      send_byte(rotl8(train_byte(pos), r), 1'b0, "");
      pos++;
    end
    $display("[TB] t2 slips=%0d min_gap=%0d lock=%0d", slip_total - s0, min_gap, lock);
    check("t2_slips", slip_total - s0, 3);
    check("t2_gap_ge_17", int'(min_gap >= 17), 1);
    check("t2_lock", int'(lock), 1);
    check("t2_slip_cnt", int'(slip_cnt), 3);
    check("t2_state", int'(state_o), 5);

    // 6: async reset mid-LOCKED clears everything without a clock edge
    @(negedge t_clk);
    rst_n    = 1'b0;
    train_en = 1'b0;
    #1;
    check("t6l_lock", int'(lock), 0);
    check("t6l_state", int'(state_o), 0);
    check("t6l_los", int'(los_cnt), 0);
    check("t6l_phase", int'(word_phase), 0);
    check("t6l_slip_cnt", int'(slip_cnt), 0);
    @(negedge t_clk);
    rst_n = 1'b1;
    @(negedge t_clk);

    // 3: constant 0x00 exhausts the slip budget
    train_en = 1'b1;
    @(negedge t_clk);
    check("t3_hunt", int'(state_o), 1);
    s0 = slip_total;
    for (int k = 0; k < 100 && fail !== 1'b1; k++) send_byte(8'h00, 1'b0, "");
    $display("[TB] t3 slips=%0d fail=%0d state=%0d", slip_total - s0, fail, state_o);
    check("t3_slips", slip_total - s0, 7);
    check("t3_fail", int'(fail), 1);
    check("t3_state", int'(state_o), 6);
    check("t3_slip_cnt", int'(slip_cnt), 7);
    check("t3_gap_ge_17", int'(min_gap >= 17), 1);
    train_en = 1'b0;
    @(negedge t_clk);
    check("t3_idle", int'(state_o), 0);
    check("t3_fail_drop", int'(fail), 0);
    train_en = 1'b1;
    @(negedge t_clk);
    check("t3_rehunt", int'(state_o), 1);
    check("t3_slip_clr", int'(slip_cnt), 0);

    // 6: async reset while a bitslip pulse is high in SLIP
    byte_vld = 1'b1;
    byte_in  = 8'h00;
    @(negedge t_clk);
    byte_vld = 1'b0;
    check("t6s_in_slip", int'(state_o), 2);
    check("t6s_pulse", int'(bitslip), 1);
    rst_n    = 1'b0;
    train_en = 1'b0;
    #1;
    check("t6s_bitslip_cut", int'(bitslip), 0);
    check("t6s_state", int'(state_o), 0);
    check("t6s_slip_cnt", int'(slip_cnt), 0);
    check("t6s_fail", int'(fail), 0);
    @(negedge t_clk);
    rst_n = 1'b1;
    @(negedge t_clk);
    check("t6s_idle_after", int'(state_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
